// File: rtl/b1_scfifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : b1_scfifo_pkg
// Purpose  : Shared state encoding and sizing helper for the B1 single-clock FIFO
// Revision : 1.0
// ============================================================================
package b1_scfifo_pkg;

    typedef enum logic [1:0] {
        ZERO_ST = 2'd0,
        NORM_ST = 2'd1,
        FULL_ST = 2'd2
    } scfifo_state_t;

    function automatic int depth(input int aw);
        return 1 << aw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/b1_scfifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : b1_scfifo_mem
// Purpose  : Simple dual-port FIFO storage; registered read, or show-ahead read
//            when B1_SCFIFO_SHOWAHEAD_EN is defined
// Revision : 1.0
// ============================================================================
module b1_scfifo_mem
    import b1_scfifo_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              we_i,
    input  logic [AWIDTH-1:0] waddr_i,
    input  logic [DWIDTH-1:0] wdata_i,
    input  logic              rdreq_i,
    input  logic              empty_i,
    input  logic [AWIDTH-1:0] raddr_i,
    output logic [DWIDTH-1:0] q_o
);

    logic [DWIDTH-1:0] mem_q [depth(AWIDTH)];
    logic              w_rd;

    assign w_rd = rdreq_i & ~empty_i;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

`ifdef B1_SCFIFO_SHOWAHEAD_EN
    // Remembers the last acknowledged word so q_o holds it while empty.
    logic [DWIDTH-1:0] last_q;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            last_q <= '0;
        end else if (w_rd) begin
            last_q <= mem_q[raddr_i];
        end
    end

    assign q_o = empty_i ? last_q : mem_q[raddr_i];
`else
    logic [DWIDTH-1:0] q_q;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            q_q <= '0;
        end else if (w_rd) begin
            q_q <= mem_q[raddr_i];
        end
    end

    assign q_o = q_q;
`endif

endmodule
`default_nettype wire

// File: rtl/b1_scfifo_thr.sv
`default_nettype none
// ============================================================================
// Module   : b1_scfifo_thr
// Purpose  : Single-clock FIFO with thresholds and sticky error flags;
//            B1_SCFIFO_SHOWAHEAD_EN selects zero-latency show-ahead reads
// Revision : 1.0
// ============================================================================
module b1_scfifo_thr
    import b1_scfifo_pkg::*;
#(
    parameter int DWIDTH             = 8,
    parameter int AWIDTH             = 8,
    parameter int ALMOST_FULL_VALUE  = (2**AWIDTH) - 4,
    parameter int ALMOST_EMPTY_VALUE = 4
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              wrreq_i,
    input  logic              rdreq_i,
    output logic [DWIDTH-1:0] q_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              almost_empty_o,
    output logic              almost_full_o,
    output logic [AWIDTH-1:0] usedw_o,
    output logic              ovf_o,
    output logic              udf_o
);

    localparam logic [AWIDTH:0] c_one      = (AWIDTH+1)'(1);
    localparam logic [AWIDTH:0] c_depth_m1 = (AWIDTH+1)'(depth(AWIDTH) - 1);
    localparam logic [AWIDTH:0] c_af_lvl   = (AWIDTH+1)'(ALMOST_FULL_VALUE);
    localparam logic [AWIDTH:0] c_ae_lvl   = (AWIDTH+1)'(ALMOST_EMPTY_VALUE);

    scfifo_state_t     state_q, state_d;
    logic [AWIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [AWIDTH:0]   count_q, count_d;
    logic              empty_q, full_q, aempty_q, afull_q, ovf_q, udf_q;
    logic              w_wr_acc, w_rd_acc;

    assign w_wr_acc = wrreq_i & ~full_q;
    assign w_rd_acc = rdreq_i & ~empty_q;

    always_comb begin
        count_d = count_q;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   count_d = count_q + c_one;
            2'b01:   count_d = count_q - c_one;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ZERO_ST: begin
                if (w_wr_acc) state_d = NORM_ST;
            end
            NORM_ST: begin
                if (w_rd_acc && !w_wr_acc && count_q == c_one) begin
                    state_d = ZERO_ST;
                end else if (w_wr_acc && !w_rd_acc && count_q == c_depth_m1) begin
                    state_d = FULL_ST;
                end
            end
            FULL_ST: begin
                if (w_rd_acc) state_d = NORM_ST;
            end
            default: state_d = ZERO_ST;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q  <= ZERO_ST;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            aempty_q <= 1'b1;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            empty_q  <= (state_d == ZERO_ST);
            full_q   <= (state_d == FULL_ST);
            aempty_q <= (count_d < c_ae_lvl);
            afull_q  <= (count_d >= c_af_lvl);
            if (w_wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_rd_acc) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (wrreq_i && full_q)  ovf_q <= 1'b1;
            if (rdreq_i && empty_q) udf_q <= 1'b1;
        end
    end

    b1_scfifo_mem #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_mem (
        .clk_i   (clk_i),
        .srst_i  (srst_i),
        .we_i    (w_wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_i),
        .rdreq_i (rdreq_i),
        .empty_i (empty_q),
        .raddr_i (rd_ptr_q),
        .q_o     (q_o)
    );

    assign empty_o        = empty_q;
    assign full_o         = full_q;
    assign almost_empty_o = aempty_q;
    assign almost_full_o  = afull_q;
    assign usedw_o        = count_q[AWIDTH-1:0];
    assign ovf_o          = ovf_q;
    assign udf_o          = udf_q;

endmodule
`default_nettype wire

// File: tb/tb_b1_scfifo_thr.sv
`default_nettype none
// ============================================================================
// Module   : tb_b1_scfifo_thr
// Purpose  : Self-checking bench for b1_scfifo_thr against a queue-based model
// Revision : 1.0
// ============================================================================
module tb_b1_scfifo_thr;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AFV   = 4;
    localparam int AEV   = 4;

    logic          clk = 1'b0;
    logic          srst_i = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic          wrreq_i = 1'b0;
    logic          rdreq_i = 1'b0;
    logic [DW-1:0] q_o;
    logic          empty_o, full_o, almost_empty_o, almost_full_o;
    logic [AW-1:0] usedw_o;
    logic          ovf_o, udf_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_q;
    logic          m_ovf;
    logic          m_udf;

    always #5 clk = ~clk;

    b1_scfifo_thr #(
        .DWIDTH             (DW),
        .AWIDTH             (AW),
        .ALMOST_FULL_VALUE  (AFV),
        .ALMOST_EMPTY_VALUE (AEV)
    ) dut (
        .clk_i          (clk),
        .srst_i         (srst_i),
        .data_i         (data_i),
        .wrreq_i        (wrreq_i),
        .rdreq_i        (rdreq_i),
        .q_o            (q_o),
        .empty_o        (empty_o),
        .full_o         (full_o),
        .almost_empty_o (almost_empty_o),
        .almost_full_o  (almost_full_o),
        .usedw_o        (usedw_o),
        .ovf_o          (ovf_o),
        .udf_o          (udf_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] exp_q();
`ifdef B1_SCFIFO_SHOWAHEAD_EN
        return (mq.size() > 0) ? mq[0] : m_q;
`else
        return m_q;
`endif
    endfunction

    task automatic compare_all();
        int cnt;
        cnt = mq.size();
        check("empty",        32'(empty_o),        32'(cnt == 0));
        check("full",         32'(full_o),         32'(cnt == DEPTH));
        check("almost_empty", 32'(almost_empty_o), 32'(cnt < AEV));
        check("almost_full",  32'(almost_full_o),  32'(cnt >= AFV));
        check("usedw",        32'(usedw_o),        32'(cnt % DEPTH));
        check("ovf",          32'(ovf_o),          32'(m_ovf));
        check("udf",          32'(udf_o),          32'(m_udf));
        check("q",            32'(q_o),            32'(exp_q()));
    endtask

    task automatic do_reset();
        srst_i  = 1'b1;
        wrreq_i = 1'b0;
        rdreq_i = 1'b0;
        @(posedge clk);
        mq.delete();
        m_q   = '0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        #1;
        srst_i = 1'b0;
        compare_all();
    endtask

    // One clock: accepts are judged on the occupancy before the edge.
    task automatic step(input logic wr, input logic rd, input logic [DW-1:0] d);
        logic was_full, was_empty;
        srst_i  = 1'b0;
        wrreq_i = wr;
        rdreq_i = rd;
        data_i  = d;
        @(posedge clk);
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        if (wr && was_full)  m_ovf = 1'b1;
        if (rd && was_empty) m_udf = 1'b1;
        if (rd && !was_empty) m_q = mq.pop_front();
        if (wr && !was_full)  mq.push_back(d);
        #1;
        wrreq_i = 1'b0;
        rdreq_i = 1'b0;
        compare_all();
    endtask

    initial begin
        int wr_pct, rd_pct;

        // Reset state
        do_reset();

        // Fill past full, then one rejected write
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h10 + 8'(i));
        step(1'b1, 1'b0, 8'hAA);

        // Drain past empty, then one rejected read
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 8'h00);

        // Steady count of 3 with concurrent traffic so pointers wrap
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h30 + 8'(i));
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 8'h40 + 8'(i));

        // Concurrent rd+wr while full, then while empty
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h60 + 8'(i));
        step(1'b1, 1'b1, 8'hEE);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b1, 8'h77);

        // Reset mid-stream with 5 words held, then a fresh word round trip
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h80 + 8'(i));
        do_reset();
        step(1'b1, 1'b0, 8'h5A);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        // Randomized traffic with biased phases and occasional reset
        for (int ph = 0; ph < 6; ph++) begin
            wr_pct = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 20 : 50;
            rd_pct = 100 - wr_pct;
            for (int i = 0; i < 250; i++) begin
                if ($urandom_range(199, 0) == 0) begin
                    do_reset();
                end else begin
                    step(32'($urandom_range(99, 0)) < wr_pct,
                         32'($urandom_range(99, 0)) < rd_pct,
                         DW'($urandom));
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
